otter_lsu_align: RTL

//  Load/store alignment unit between the pipeline MEM stage and port 2 (data port) of the dual-port OTTER memory.

---
 rtl/otter_lsu_align.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/otter_lsu_align.sv
// Load/store alignment unit for the OTTER data port: splits word-crossing
// accesses, merges split reads and applies lb/lh/lw/lbu/lhu extension.
module otter_lsu_align #(
    parameter logic [31:0] IO_BASE = 32'h11000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr2,
    output logic [31:0] mem_din2,
    output logic        mem_write2,
    output logic        mem_read2,
    output logic [1:0]  mem_size,
    output logic        mem_sign,
    input  logic [31:0] mem_dout2
);

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        WR,
        WRB
    } state_t;

    state_t      state, state_n;

    logic [31:0] addr_q, addr_n;
    logic [31:0] wdata_q, wdata_n;
    logic [1:0]  size_q, size_n;
    logic        sign_q, sign_n;
    logic        mmio_q, mmio_n;
    logic        cross_q, cross_n;
    logic [31:0] lo_q, lo_n;
    logic [2:0]  cnt_q, cnt_n;

    logic [31:0] addr2_n;
    logic [31:0] din2_n;
    logic        write2_n;
    logic        read2_n;
    logic [1:0]  size2_n;
    logic        rsp_valid_n;
    logic        rsp_err_n;
    logic [31:0] rdata_n;

    logic        req_mmio;
    logic        req_cross;
    logic [31:0] base_word;
    logic [2:0]  byte_last;

    // pair holds {hi,lo}; MMIO words bypass shifting and extension entirely
    function automatic logic [31:0] load_result(
        input logic [63:0] pair,
        input logic [1:0]  off,
        input logic [1:0]  size,
        input logic        uns,
        input logic        mmio
    );
        logic [31:0] w;
        w = 32'(pair >> {off, 3'b000});
        if (mmio) begin
            return pair[31:0];
        end
        case (size)
            2'd0:    return uns ? {24'b0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
            2'd1:    return uns ? {16'b0, w[15:0]} : {{16{w[15]}}, w[15:0]};
            default: return w;
        endcase
    endfunction

    assign req_ready = (state == IDLE);
    assign mem_sign  = 1'b0;

    assign req_mmio  = (req_addr >= IO_BASE);
    assign req_cross = !req_mmio &&
                       (((req_size == 2'd1) && (req_addr[1:0] == 2'd3)) ||
                        ((req_size == 2'd2) && (req_addr[1:0] != 2'd0)));
    assign base_word = {addr_q[31:2], 2'b00};
    assign byte_last = (size_q == 2'd1) ? 3'd2 : 3'd4;

    always_comb begin
        state_n     = state;
        addr_n      = addr_q;
        wdata_n     = wdata_q;
        size_n      = size_q;
        sign_n      = sign_q;
        mmio_n      = mmio_q;
        cross_n     = cross_q;
        lo_n        = lo_q;
        cnt_n       = cnt_q;
        addr2_n     = '0;
        din2_n      = '0;
        write2_n    = 1'b0;
        read2_n     = 1'b0;
        size2_n     = 2'd0;
        rsp_valid_n = 1'b0;
        rsp_err_n   = 1'b0;
        rdata_n     = '0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    if ((req_size == 2'd3) || (req_mmio && (req_addr[1:0] != 2'd0))) begin
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = 1'b1;
                    end else begin
                        addr_n  = req_addr;
                        wdata_n = req_wdata;
                        size_n  = req_size;
                        sign_n  = req_sign;
                        mmio_n  = req_mmio;
                        cross_n = req_cross;
                        if (!req_we) begin
                            state_n = RD0;
                            read2_n = 1'b1;
                            addr2_n = {req_addr[31:2], 2'b00};
                            size2_n = 2'd2;
                        end else if (req_cross) begin
                            // first byte goes out now; cnt names the next byte to issue
                            state_n  = WRB;
                            write2_n = 1'b1;
                            addr2_n  = req_addr;
                            size2_n  = 2'd0;
                            din2_n   = {24'b0, req_wdata[7:0]};
                            cnt_n    = 3'd1;
                        end else begin
                            state_n  = WR;
                            write2_n = 1'b1;
                            addr2_n  = req_addr;
                            size2_n  = req_size;
                            din2_n   = req_wdata;
                        end
                    end
                end
            end

            RD0: begin
                lo_n = mem_dout2;
                if (cross_q) begin
                    state_n = RD1;
                    read2_n = 1'b1;
                    addr2_n = base_word + 32'd4;
                    size2_n = 2'd2;
                end else begin
                    state_n     = IDLE;
                    rsp_valid_n = 1'b1;
                    rdata_n     = load_result({32'b0, mem_dout2}, addr_q[1:0],
                                              size_q, sign_q, mmio_q);
                end
            end

            RD1: begin
                state_n     = IDLE;
                rsp_valid_n = 1'b1;
                rdata_n     = load_result({mem_dout2, lo_q}, addr_q[1:0],
                                          size_q, sign_q, mmio_q);
            end

            WR: begin
                state_n     = IDLE;
                rsp_valid_n = 1'b1;
            end

            WRB: begin
                if (cnt_q == byte_last) begin
                    state_n     = IDLE;
                    rsp_valid_n = 1'b1;
                end else begin
                    write2_n = 1'b1;
                    size2_n  = 2'd0;
                    addr2_n  = addr_q + {29'b0, cnt_q};
                    din2_n   = {24'b0, 8'(wdata_q >> {cnt_q[1:0], 3'b000})};
                    cnt_n    = cnt_q + 3'd1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= 2'd0;
            sign_q     <= 1'b0;
            mmio_q     <= 1'b0;
            cross_q    <= 1'b0;
            lo_q       <= '0;
            cnt_q      <= 3'd0;
            mem_addr2  <= '0;
            mem_din2   <= '0;
            mem_write2 <= 1'b0;
            mem_read2  <= 1'b0;
            mem_size   <= 2'd0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            state      <= state_n;
            addr_q     <= addr_n;
            wdata_q    <= wdata_n;
            size_q     <= size_n;
            sign_q     <= sign_n;
            mmio_q     <= mmio_n;
            cross_q    <= cross_n;
            lo_q       <= lo_n;
            cnt_q      <= cnt_n;
            mem_addr2  <= addr2_n;
            mem_din2   <= din2_n;
            mem_write2 <= write2_n;
            mem_read2  <= read2_n;
            mem_size   <= size2_n;
            rsp_valid  <= rsp_valid_n;
            rsp_err    <= rsp_err_n;
            rsp_rdata  <= rdata_n;
        end
    end

endmodule
